uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial transmit half of the UART interface, sending 8N1 frames (start bit, 8 data bits LSB-first, 1 stop bit) at one bit per `i_CLK_ENABLE` strobe. It sits beside `uart_receiver` on the same clock and bit-rate enable, so a looped-back `o_TX` → `i_RX` path round-trips a byte. A one-deep ready/start handshake accepts bytes from the host logic.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame. Only 8 is supported, for compatibility with `uart_receiver`.
- `i_CLK`  in  1: system clock; all logic on rising edge.
- `i_RESET`  in  1: synchronous, active-high reset.
- `i_CLK_ENABLE`  in  1: bit-rate strobe; one strobe equals one bit period.
- `i_TX_START`  in  1: request to send `i_DATA`; sampled only while `o_TX_READY` = 1.
- `i_DATA`  in  DATA_WIDTH: byte to send; captured in the accept cycle.
- `o_TX`  out  1: serial line, registered, idle-high.
- `o_TX_READY`  out  1: transmitter can accept a byte.
- `o_TX_DONE`  out  1: one-cycle pulse when the stop bit starts driving.

## Operation
- State register `r_CURRENT_STATE` (2 bits) with states IDLE, START, DATA, STOP. Also `r_BIT_COUNT` (4 bits) and `r_DATA_REG` (8 bits).
- Reset values: `o_TX` = 1, `o_TX_READY` = 1, `o_TX_DONE` = 0, state = IDLE, `r_BIT_COUNT` = 0, `r_DATA_REG` = 0.
- IDLE:
  - `o_TX` holds 1.
  - If `i_TX_START` is high: `r_DATA_REG` ← `i_DATA`, `o_TX_READY` ← 0, go to START. This does not depend on `i_CLK_ENABLE`.
- START: on a strobe, `o_TX` ← 0, `r_BIT_COUNT` ← 0, go to DATA.
- DATA: on a strobe, `o_TX` ← `r_DATA_REG[r_BIT_COUNT]` and `r_BIT_COUNT` increments. When the count is 7, go to STOP instead of incrementing further.
- STOP: on a strobe, `o_TX` ← 1, `o_TX_DONE` ← 1 for exactly one cycle, `o_TX_READY` ← 1, go to IDLE.
- With `i_CLK_ENABLE` low, state, count, data and `o_TX` hold.
- `o_TX_DONE` is 0 in every cycle other than the STOP-exit cycle.
- `i_TX_START` while `o_TX_READY` = 0 is ignored, not queued.
- Changes to `i_DATA` after the accept cycle have no effect on the frame in flight.
- Reset mid-frame: on the next edge every output takes its reset value; the partial frame is abandoned and the line returns high.
- Reset has priority over start and strobe in the same cycle.

## Timing
- Accept cycle A. The first strobe strictly after A, E1, drives the start bit.
- Strobes E2..E9 drive d0..d7; E10 drives the stop bit.
- In the E10 cycle: `o_TX_DONE` = 1 and `o_TX_READY` = 1.
- Back-to-back: the earliest next accept is the cycle after E10, and its start bit goes out at E11. The stop bit is therefore exactly one period long, with no idle gap.
- A strobe in cycle A itself is not counted.
- Each `o_TX` change appears one clock after the strobe edge (registered output).
- Frame length is 10 bit periods (11 with parity).

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: DATA continues one extra bit. At `r_BIT_COUNT` = 8, `o_TX` ← even parity (XOR of `r_DATA_REG`), then go to STOP. Stop is driven at E11.
- Undefined: 8N1 as above, with no parity logic present.
- The peer receiver must be built with matching framing.

## Structure
- Shared package `uart_pkg`: state encoding constants (IDLE = 2'b00, START = 01, DATA = 10, STOP = 11), `UART_DATA_WIDTH` = 8, `UART_IDLE_LEVEL` = 1'b1. Both `uart_receiver` and `uart_transmitter` use it.
- No sub-module needed. Parity is a single reduction XOR, kept inline.
- Formal properties are guarded by the existing formal define and use the `r_PAST_VALID` pattern. Required properties:
  - `o_TX` = 1 whenever in IDLE.
  - `o_TX_DONE` is never high for two consecutive cycles.
  - `r_BIT_COUNT` ≤ 8.

## Test plan
- Reset, then `i_CLK_ENABLE` held 1, send 0xA5 → `o_TX` sequence 0,1,0,1,0,0,1,0,1,1 on successive cycles; `o_TX_DONE` high in the cycle of the final 1.
- Strobe every 4th cycle, send 0x00 → line low for 36 cycles (start + 8 data bits), then high; `o_TX_READY` low from the accept cycle until the stop strobe.
- Two bytes back-to-back, 0x3C then 0xC3, with start asserted the cycle after `o_TX_DONE` → the second start bit follows exactly one stop-bit period; no extra idle.
- `i_TX_START` pulsed with 0xFF while busy sending 0x12 → only 0x12 is transmitted; exactly one `o_TX_DONE`.
- `i_RESET` asserted after the third data bit → next cycle `o_TX` = 1, `o_TX_READY` = 1, `o_TX_DONE` = 0; the following send of 0x81 is a clean frame.
- With `UART_TX_PARITY_EN`, send 0x07 → parity bit 1 before stop; send 0x03 → parity bit 0. Loopback into the matching receiver gives `o_DATA` equal to the sent byte and `o_FRAMING_ERROR` = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and framing constants
package uart_pkg;

    // Serial engine states shared by transmitter and receiver
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam int   UART_DATA_WIDTH = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter, optional even parity via UART_TX_PARITY_EN
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET,
    input  logic                  i_CLK_ENABLE,
    input  logic                  i_TX_START,
    input  logic [DATA_WIDTH-1:0] i_DATA,
    output logic                  o_TX,
    output logic                  o_TX_READY,
    output logic                  o_TX_DONE
);

    uart_state_t           r_CURRENT_STATE;
    logic [3:0]            r_BIT_COUNT;
    logic [DATA_WIDTH-1:0] r_DATA_REG;

`ifdef UART_TX_PARITY_EN
    // Final data-phase slot carries the even-parity bit instead of a payload bit
    localparam logic [3:0] LAST_SLOT = 4'd8;
`else
    localparam logic [3:0] LAST_SLOT = 4'd7;
`endif

    // Frame sequencer: accept a byte in IDLE, then advance one bit per strobe
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_CURRENT_STATE <= IDLE;
            r_BIT_COUNT     <= 4'd0;
            r_DATA_REG      <= '0;
            o_TX            <= UART_IDLE_LEVEL;
            o_TX_READY      <= 1'b1;
            o_TX_DONE       <= 1'b0;
        end else begin
            o_TX_DONE <= 1'b0;
            case (r_CURRENT_STATE)
                IDLE: begin
                    o_TX <= UART_IDLE_LEVEL;
                    if (i_TX_START) begin
                        r_DATA_REG      <= i_DATA;
                        o_TX_READY      <= 1'b0;
                        r_CURRENT_STATE <= START;
                    end
                end
                START: begin
                    if (i_CLK_ENABLE) begin
                        o_TX            <= ~UART_IDLE_LEVEL;
                        r_BIT_COUNT     <= 4'd0;
                        r_CURRENT_STATE <= DATA;
                    end
                end
                DATA: begin
                    if (i_CLK_ENABLE) begin
`ifdef UART_TX_PARITY_EN
                        if (r_BIT_COUNT == 4'd8) begin
                            o_TX <= ^r_DATA_REG;
                        end else begin
                            o_TX <= r_DATA_REG[r_BIT_COUNT[2:0]];
                        end
`else
                        o_TX <= r_DATA_REG[r_BIT_COUNT[2:0]];
`endif
                        if (r_BIT_COUNT == LAST_SLOT) begin
                            r_CURRENT_STATE <= STOP;
                        end else begin
                            r_BIT_COUNT <= r_BIT_COUNT + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (i_CLK_ENABLE) begin
                        o_TX            <= UART_IDLE_LEVEL;
                        o_TX_DONE       <= 1'b1;
                        o_TX_READY      <= 1'b1;
                        r_CURRENT_STATE <= IDLE;
                    end
                end
                default: r_CURRENT_STATE <= IDLE;
            endcase
        end
    end

`ifdef FORMAL
    logic r_PAST_VALID;
    logic r_PREV_DONE;

    // Track that at least one non-reset cycle has elapsed, and the last done value
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_PAST_VALID <= 1'b0;
            r_PREV_DONE  <= 1'b0;
        end else begin
            r_PAST_VALID <= 1'b1;
            r_PREV_DONE  <= o_TX_DONE;
        end
    end

    // Line idles high, done is a single-cycle pulse, count stays in range
    always_comb begin
        if (r_PAST_VALID) begin
            if (r_CURRENT_STATE == IDLE) assert (o_TX == UART_IDLE_LEVEL);
            assert (!(r_PREV_DONE && o_TX_DONE));
            assert (r_BIT_COUNT <= 4'd8);
        end
    end
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed scoreboard bench for uart_transmitter
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_enable;
    logic       tx_start;
    logic [7:0] data;
    logic       tx;
    logic       tx_ready;
    logic       tx_done;

    int   vectors = 0;
    int   miscompares = 0;
    int   period = 1;
    int   phase = 0;
    int   cyc = 0;
    logic prev_en = 1'b0;
    int   done_cycle = 0;
    int   first_bit_cycle = 0;
    int   saved_done = 0;
    logic exp_q[$];

    uart_transmitter dut (
        .i_CLK        (clk),
        .i_RESET      (reset),
        .i_CLK_ENABLE (clk_enable),
        .i_TX_START   (tx_start),
        .i_DATA       (data),
        .o_TX         (tx),
        .o_TX_READY   (tx_ready),
        .o_TX_DONE    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: remember the strobe seen by this edge, sample 1 time unit later
    task automatic step();
        prev_en = clk_enable;
        @(posedge clk);
        #1;
        cyc++;
        phase++;
        clk_enable = ((phase % period) == 0);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle_tx", tx, 1);
            check("idle_done", tx_done, 0);
            check("idle_ready", tx_ready, 1);
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input int poke_at, input int reset_at);
        int   idx;
        int   guard;
        logic cur;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_q.push_back(1'b1);
        tx_start = 1'b1;
        data     = d;
        step();
        check("accept_ready", tx_ready, 0);
        tx_start = 1'b0;
        data     = ~d;
        cur   = 1'b1;
        idx   = 0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 64 * period) begin
            if (idx == poke_at) begin
                tx_start = 1'b1;
                data     = 8'hFF;
            end
            step();
            guard++;
            tx_start = 1'b0;
            if (prev_en) begin
                cur = exp_q.pop_front();
                idx++;
                if (idx == 1) first_bit_cycle = cyc;
                check("tx_bit", tx, cur);
                if (exp_q.size() == 0) begin
                    check("stop_done", tx_done, 1);
                    check("stop_ready", tx_ready, 1);
                    done_cycle = cyc;
                end else begin
                    check("busy_done", tx_done, 0);
                    check("busy_ready", tx_ready, 0);
                end
                if (idx == reset_at) begin
                    reset = 1'b1;
                    step();
                    reset = 1'b0;
                    check("rst_tx", tx, 1);
                    check("rst_ready", tx_ready, 1);
                    check("rst_done", tx_done, 0);
                    exp_q.delete();
                end
            end else begin
                check("tx_hold", tx, cur);
                check("hold_done", tx_done, 0);
            end
        end
        if (exp_q.size() != 0) begin
            check("frame_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        reset      = 1'b1;
        clk_enable = 1'b0;
        tx_start   = 1'b0;
        data       = 8'h00;
        period     = 1;
        step();
        step();
        check("reset_tx", tx, 1);
        check("reset_ready", tx_ready, 1);
        check("reset_done", tx_done, 0);
        reset = 1'b0;
        step();

        // 0xA5 with a strobe every cycle
        period = 1;
        run_frame(8'hA5, -1, -1);
        idle_check(3);

        // 0x00 with a strobe every 4th cycle
        period = 4;
        run_frame(8'h00, -1, -1);
        idle_check(4);

        // Back-to-back 0x3C then 0xC3, start the cycle after done
        run_frame(8'h3C, -1, -1);
        saved_done = done_cycle;
        run_frame(8'hC3, -1, -1);
        check("b2b_gap", first_bit_cycle - saved_done, period);
        idle_check(4);

        // Start pulse with 0xFF while 0x12 is in flight
        period = 2;
        run_frame(8'h12, 3, -1);
        idle_check(12);

        // Reset after the third data bit, then a clean 0x81
        period = 3;
        run_frame(8'h5A, -1, 4);
        run_frame(8'h81, -1, -1);
        idle_check(6);

        // Parity-sensitive patterns
        period = 1;
        run_frame(8'h07, -1, -1);
        run_frame(8'h03, -1, -1);
        idle_check(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
